// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path: ALU ops, opcodes, states, mux selects.
// Pure definitions; no latency or flow control of its own.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_RTYPE = 3'b010,
    ALU_ITYPE = 3'b011
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EX   = 4'd10,
    ST_ADDI_WB   = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    SRCB_REG      = 2'b00,
    SRCB_FOUR     = 2'b01,
    SRCB_IMM      = 2'b10,
    SRCB_IMM_SHL2 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU     = 2'b00,
    PCSRC_ALU_OUT = 2'b01,
    PCSRC_JUMP    = 2'b10
  } pc_source_t;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    pc_source_t pc_source;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_error;
  } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expired is combinational on the wait cycle that reaches MEM_TIMEOUT.
// No flow control; clear has priority over count_en, MEM_TIMEOUT=0 never expires.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  // The current wait cycle is counted before comparing, hence the -1.
  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = count_en && (cnt == TO_W'(MEM_TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM: fetch/decode/execute/mem/writeback; lw 5, sw/R/addi 4, beq/j 3 cycles at zero wait.
// Stalls in memory states until Mem_Ready; watchdog abandons the instruction and refetches on expiry.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       Mem_Ready,
  output logic       PC_Write,
  output logic       IorD,
  output logic       Mem_Read,
  output logic       Mem_Write,
  output logic       IR_Write,
  output logic       Reg_Write,
  output logic       Reg_Dst,
  output logic       Mem_To_Reg,
  output logic       ALU_Src_A,
  output logic [1:0] ALU_Src_B,
  output logic [2:0] ALU_Op,
  output logic [1:0] PC_Source,
  output logic       Instr_Done,
  output logic       Illegal_Op,
  output logic       Mem_Error
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctl;
  logic   wait_cyc;
  logic   expired;
  logic   timer_clear;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  assign wait_cyc = !reset && !Mem_Ready &&
                    ((state == ST_FETCH) || (state == ST_MEM_READ) || (state == ST_MEM_WRITE));

  // Any state change (including the expiry restart of FETCH) starts a fresh wait window.
  assign timer_clear = (state_nxt != state) || expired;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .count_en(wait_cyc),
    .expired (expired)
  );

  always_comb begin
    ctl       = '0;
    state_nxt = state;
    case (state)
      ST_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALU_ADD;
        ctl.pc_source = PCSRC_ALU;
        ctl.ir_write  = Mem_Ready;
        ctl.pc_write  = Mem_Ready;
        if (Mem_Ready) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        ctl.alu_src_b = SRCB_IMM_SHL2;
        ctl.alu_op    = ALU_ADD;
        case (Opcode)
          OP_LW, OP_SW: state_nxt = ST_MEM_ADDR;
          OP_RTYPE:     state_nxt = ST_EXECUTE;
          OP_BEQ:       state_nxt = ST_BRANCH;
          OP_J:         state_nxt = ST_JUMP;
          OP_ADDI:      state_nxt = ST_ADDI_EX;
          default: begin
            ctl.illegal_op = 1'b1;
            state_nxt      = ST_FETCH;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_ITYPE;
        state_nxt     = (Opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      end
      ST_MEM_READ: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
        if (Mem_Ready) state_nxt = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.instr_done = 1'b1;
        state_nxt      = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        ctl.mem_write  = 1'b1;
        ctl.iord       = 1'b1;
        ctl.instr_done = Mem_Ready;
        if (Mem_Ready) state_nxt = ST_FETCH;
      end
      ST_EXECUTE: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_REG;
        ctl.alu_op    = ALU_RTYPE;
        state_nxt     = ST_R_WB;
      end
      ST_R_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = 1'b1;
        ctl.instr_done = 1'b1;
        state_nxt      = ST_FETCH;
      end
      ST_BRANCH: begin
        ctl.alu_src_a  = 1'b1;
        ctl.alu_src_b  = SRCB_REG;
        ctl.alu_op     = ALU_SUB;
        ctl.pc_source  = PCSRC_ALU_OUT;
        ctl.pc_write   = Zero;
        ctl.instr_done = 1'b1;
        state_nxt      = ST_FETCH;
      end
      ST_JUMP: begin
        ctl.pc_source  = PCSRC_JUMP;
        ctl.pc_write   = 1'b1;
        ctl.instr_done = 1'b1;
        state_nxt      = ST_FETCH;
      end
      ST_ADDI_EX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_ADD;
        state_nxt     = ST_ADDI_WB;
      end
      ST_ADDI_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        state_nxt      = ST_FETCH;
      end
      default: state_nxt = ST_FETCH;
    endcase

    // Expiry only fires with Mem_Ready low, so IR/PC strobes and Instr_Done are already 0 here.
    if (expired) begin
      ctl.mem_read  = 1'b0;
      ctl.mem_write = 1'b0;
      ctl.mem_error = 1'b1;
      state_nxt     = ST_FETCH;
    end

    if (reset) ctl = '0;
  end

  assign PC_Write   = ctl.pc_write;
  assign IorD       = ctl.iord;
  assign Mem_Read   = ctl.mem_read;
  assign Mem_Write  = ctl.mem_write;
  assign IR_Write   = ctl.ir_write;
  assign Reg_Write  = ctl.reg_write;
  assign Reg_Dst    = ctl.reg_dst;
  assign Mem_To_Reg = ctl.mem_to_reg;
  assign ALU_Src_A  = ctl.alu_src_a;
  assign ALU_Src_B  = ctl.alu_src_b;
  assign ALU_Op     = ctl.alu_op;
  assign PC_Source  = ctl.pc_source;
  assign Instr_Done = ctl.instr_done;
  assign Illegal_Op = ctl.illegal_op;
  assign Mem_Error  = ctl.mem_error;

endmodule

// File: tb/tb_multicycle_control.sv
// Random instruction/Mem_Ready/reset stream against an instruction-level step-queue model of the controller.
// Every cycle the full output bundle is compared at the falling edge.
module tb_multicycle_control;

  localparam int TMO    = 4;
  localparam int CYCLES = 4000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Opcode = 6'h00;
  logic       Zero = 1'b0;
  logic       Mem_Ready = 1'b0;
  logic       PC_Write, IorD, Mem_Read, Mem_Write, IR_Write, Reg_Write, Reg_Dst, Mem_To_Reg;
  logic       ALU_Src_A, Instr_Done, Illegal_Op, Mem_Error;
  logic [1:0] ALU_Src_B, PC_Source;
  logic [2:0] ALU_Op;

  multicycle_control #(.MEM_TIMEOUT(TMO), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .Mem_Ready(Mem_Ready),
    .PC_Write(PC_Write), .IorD(IorD), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .IR_Write(IR_Write), .Reg_Write(Reg_Write), .Reg_Dst(Reg_Dst), .Mem_To_Reg(Mem_To_Reg),
    .ALU_Src_A(ALU_Src_A), .ALU_Src_B(ALU_Src_B), .ALU_Op(ALU_Op), .PC_Source(PC_Source),
    .Instr_Done(Instr_Done), .Illegal_Op(Illegal_Op), .Mem_Error(Mem_Error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  // Instruction steps as seen from the outside; an instruction is a FETCH followed by a planned list.
  typedef enum {FETCH, DEC, ADDR, RD, MWB, WR, EXE, RWB, BR, JMP, AEX, AWB} step_t;
  step_t cur = FETCH;
  step_t plan[$];
  int    waits = 0;

  logic [5:0] legal_ops [7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h23};

  initial begin
    logic        pcw, iord, mrd, mwr, irw, rw, rdst, m2r, sa, done, ill, merr, adv, mem_wait;
    logic [1:0]  sb, ps;
    logic [2:0]  op;
    logic [31:0] exp_v, obs_v;
    int          r;

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(posedge clk);
      #1;
      reset     = (cyc < 2) || ($urandom_range(0, 299) == 0);
      Zero      = 1'($urandom_range(0, 1));
      Mem_Ready = ($urandom_range(0, 99) < 55);
      if (cur == FETCH) begin
        r = $urandom_range(0, 7);
        Opcode = (r == 7) ? 6'($urandom_range(0, 63)) : legal_ops[r];
      end
      #4;

      {pcw, iord, mrd, mwr, irw, rw, rdst, m2r, sa, done, ill, merr} = '0;
      sb = 2'b00; ps = 2'b00; op = 3'b000;
      adv = 1'b0; mem_wait = 1'b0;

      if (reset) begin
        cur = FETCH;
        plan.delete();
        waits = 0;
      end else begin
        case (cur)
          FETCH: begin
            mrd = 1'b1; sb = 2'b01;
            if (Mem_Ready) begin irw = 1'b1; pcw = 1'b1; adv = 1'b1; end
            else mem_wait = 1'b1;
          end
          DEC: begin
            sb = 2'b11; adv = 1'b1;
            case (Opcode)
              6'h23: begin plan.push_back(ADDR); plan.push_back(RD); plan.push_back(MWB); end
              6'h2B: begin plan.push_back(ADDR); plan.push_back(WR); end
              6'h00: begin plan.push_back(EXE); plan.push_back(RWB); end
              6'h04: plan.push_back(BR);
              6'h02: plan.push_back(JMP);
              6'h08: begin plan.push_back(AEX); plan.push_back(AWB); end
              default: ill = 1'b1;
            endcase
          end
          ADDR: begin sa = 1'b1; sb = 2'b10; op = 3'b011; adv = 1'b1; end
          RD: begin
            mrd = 1'b1; iord = 1'b1;
            if (Mem_Ready) adv = 1'b1; else mem_wait = 1'b1;
          end
          MWB: begin rw = 1'b1; m2r = 1'b1; done = 1'b1; adv = 1'b1; end
          WR: begin
            mwr = 1'b1; iord = 1'b1;
            if (Mem_Ready) begin done = 1'b1; adv = 1'b1; end
            else mem_wait = 1'b1;
          end
          EXE: begin sa = 1'b1; op = 3'b010; adv = 1'b1; end
          RWB: begin rw = 1'b1; rdst = 1'b1; done = 1'b1; adv = 1'b1; end
          BR:  begin sa = 1'b1; op = 3'b001; ps = 2'b01; pcw = Zero; done = 1'b1; adv = 1'b1; end
          JMP: begin ps = 2'b10; pcw = 1'b1; done = 1'b1; adv = 1'b1; end
          AEX: begin sa = 1'b1; sb = 2'b10; adv = 1'b1; end
          AWB: begin rw = 1'b1; done = 1'b1; adv = 1'b1; end
          default: adv = 1'b1;
        endcase

        if (mem_wait) begin
          waits++;
          if (waits == TMO) begin
            merr = 1'b1; mrd = 1'b0; mwr = 1'b0;
            plan.delete();
            cur = FETCH;
            waits = 0;
          end
        end
        if (adv) begin
          waits = 0;
          cur = (plan.size() > 0) ? plan.pop_front() : (cur == FETCH ? DEC : FETCH);
        end
      end

      exp_v = {13'd0, pcw, iord, mrd, mwr, irw, rw, rdst, m2r, sa, sb, op, ps, done, ill, merr};
      obs_v = {13'd0, PC_Write, IorD, Mem_Read, Mem_Write, IR_Write, Reg_Write, Reg_Dst, Mem_To_Reg,
               ALU_Src_A, ALU_Src_B, ALU_Op, PC_Source, Instr_Done, Illegal_Op, Mem_Error};
      check_val($sformatf("cycle%0d_ctrl", cyc), obs_v, exp_v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
